// File: rtl/bin_to_bcd3_if.sv
// Handshake bundle between a conversion controller and bin_to_bcd3.
// The controller side (master) drives the request; the converter (slave) returns status and result.
interface bin_to_bcd3_if;
  logic        start;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/bin_to_bcd3.sv
// Sequential 10-bit binary to 3-digit packed BCD converter (shift-and-add-3, one bit per clock).
// Results saturate to 999 with ovf set when the captured input exceeds 999.
module bin_to_bcd3 (
  input  logic         clk,
  input  logic         rst,
  bin_to_bcd3_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [21:0] shift_reg, shift_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        ovf_cap_reg, ovf_cap_next;
  logic [11:0] bcd_reg, bcd_next;
  logic        ovf_reg, ovf_next;
  logic        done_reg, done_next;

  logic [11:0] adj;
  logic [21:0] shifted;

  // Digits are corrected independently; no carry ever crosses a digit boundary.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = shift_reg[10 + 4*gi +: 4];
      assign adj[4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  endgenerate

  assign shifted = {adj, shift_reg[9:0]} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      ovf_cap_reg <= 1'b0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      ovf_cap_reg <= ovf_cap_next;
      bcd_reg     <= bcd_next;
      ovf_reg     <= ovf_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    ovf_cap_next = ovf_cap_reg;
    bcd_next     = bcd_reg;
    ovf_next     = ovf_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shift_next   = {12'h000, bus.bin};
          ovf_cap_next = (bus.bin > 10'd999);
          cnt_next     = 4'd0;
          state_next   = CONV;
        end
      end
      CONV: begin
        shift_next = shifted;
        cnt_next   = cnt_reg + 4'd1;
        if (cnt_reg == 4'd9) begin
          // Above 999 the hundreds digit is meaningless, so report the saturated value.
          bcd_next   = ovf_cap_reg ? 12'h999 : shifted[21:10];
          ovf_next   = ovf_cap_reg;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == CONV);
  assign bus.done = done_reg;
  assign bus.bcd  = bcd_reg;
  assign bus.ovf  = ovf_reg;

endmodule
